audio_sample_feeder: RTL and testbench
======================================

# audio_sample_feeder

Byte-stream to stereo-sample buffer sitting directly upstream of the I2S transmitter. Accepts the little-endian 16-bit stereo PCM byte stream from the SD-card reader. Assembles L/R frames into a FIFO and presents the head frame as `left_data`/`right_data`, advancing on each `read_data_en` pulse from the transmitter. Provides a refill request to the SD reader and flags underruns.

## Interface
- `FIFO_AW`, 9: FIFO address width; depth = 2^FIFO_AW stereo frames.
- `REQ_LEVEL`, 256: `data_req` asserted while FIFO level < REQ_LEVEL.
- `clk` in 1: system clock, same clock as the transmitter.
- `rst` in 1: synchronous, active-high reset.
- `byte_valid` in 1: PCM byte present on `byte_data`.
- `byte_data` in 8: PCM byte, order L-lo, L-hi, R-lo, R-hi.
- `byte_ready` out 1: byte accepted when `byte_valid && byte_ready`.
- `frame_sync` in 1: realign byte phase to L-lo. Pulsed at the start of the data chunk.
- `read_data_en` in 1: single-cycle pulse from the transmitter; consume the head frame.
- `left_data` out 32: current left sample, `{hi, lo, 16'h0000}`.
- `right_data` out 32: current right sample, same format.
- `fifo_level` out FIFO_AW+1: frames stored, including a pending push.
- `data_req` out 1: refill request to the SD reader.
- `underrun` out 1: one-cycle pulse when `read_data_en` finds the FIFO empty.
- `underrun_cnt` out 16: only with the macro (see Configuration).

## Operation
- Assembler has phase counter 0..3 and a 24-bit partial register.
  - Each accepted byte advances the phase (3 wraps to 0).
  - Acceptance at phase 3 forms the 32-bit frame `{Rhi,Rlo,Lhi,Llo}` and pushes it into the FIFO on the next edge.
- `byte_ready` = `fifo_level < 2^FIFO_AW`, where `fifo_level` counts the pending push. No frame is ever dropped on full.
- `frame_sync`:
  - Phase is forced to 0 and partial bytes are discarded; the FIFO is untouched.
  - If coincident with an accepted byte, that byte is taken as phase 0 (L-lo).
- Output stage, on `read_data_en`:
  - FIFO non-empty: pop the head frame into the output registers.
  - FIFO empty: load zeros into the output registers and pulse `underrun`.
- Between pulses the outputs hold constant for the whole LRC period.
- Push and pop in the same cycle: level unchanged. Pop from a level-1 FIFO with a simultaneous push: pop succeeds and level stays 1.
- `data_req` = `fifo_level < REQ_LEVEL`, registered.
- Reset values:
  - Phase 0, FIFO empty, `fifo_level` 0.
  - `left_data`/`right_data` 0, `underrun` 0, `byte_ready` 0 during reset then 1.
  - `data_req` 1 after the first post-reset edge.
- Reset mid-frame discards partial bytes and all FIFO contents.

## Timing
- The transmitter latches `left_data`/`right_data` on the same edge that it raises `read_data_en`. The pulse therefore means "advance to next"; the presented frame must already be valid.
- Pop latency: `read_data_en` sampled high at edge N. FIFO RAM read is issued at N and data is available at N+1. `left_data`/`right_data` are updated at edge N+2.
- `underrun` pulses at N+1. `fifo_level` decrements at N+1.
- Push latency: phase-3 byte accepted at edge M. Frame is written at M+1. It is poppable by a `read_data_en` sampled at M+2 or later.
- Throughput: one byte per clock sustained while not full.
- `read_data_en` pulses are at least 64 BCLK apart, far more than 2 clk. Back-to-back pops need not be supported.

## Configuration
- `AUDIO_FEEDER_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt` port exists.
  - Increments on each `underrun` pulse, saturating at 16'hFFFF; cleared only by `rst`.
- Not defined:
  - Port and counter are absent.
  - `underrun` pulse behaviour is unchanged.

## Structure
- Shared package `audio_pkg`:
  - `SAMPLE_W`=16, `FRAME_W`=32.
  - Byte-phase enum: `PH_LLO`, `PH_LHI`, `PH_RLO`, `PH_RHI`.
- Sub-module `sync_fifo_1r1w`:
  - Parameterised width/address width, synchronous-read RAM, registered level.
  - Reusable by other buffering stages.
- Top holds the assembler, output registers, `data_req` and underrun logic.

## Test plan
- **Single frame:** reset, then stream bytes 34 12 78 56.
  - Pulse `read_data_en`.
  - At N+2: `left_data`=32'h1234_0000, `right_data`=32'h5678_0000; `fifo_level` 1→0.
- **Underrun:** pulse `read_data_en` with the FIFO empty.
  - Outputs become 0 at N+2; `underrun` high for exactly one cycle at N+1.
  - With the macro, `underrun_cnt`=1.
- **Full FIFO:** stream 4·2^FIFO_AW+4 bytes with no reads.
  - `byte_ready` falls once the last frame's phase-3 byte is accepted; `fifo_level`=512.
  - One read frees a slot and the stalled frame then completes intact.
- **Resync:** send 2 bytes, pulse `frame_sync`, send AA BB CC DD.
  - Popped frame: `left_data`=32'hBBAA_0000, `right_data`=32'hDDCC_0000.
- **Simultaneous push/pop at level 1:** level stays 1 and frame order is preserved. `data_req` toggles when crossing 256.
- **Reset mid-operation:** assert `rst` with 100 frames buffered.
  - Next cycle: `fifo_level`=0, outputs 0, `data_req`=1.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared definitions for the audio sample feeder: sample/frame widths, byte-phase
// encoding and the helper that places a 16-bit sample in a 32-bit I2S slot.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int FRAME_W  = 32;

  typedef enum logic [1:0] {
    PH_LLO = 2'd0,
    PH_LHI = 2'd1,
    PH_RLO = 2'd2,
    PH_RHI = 2'd3
  } byte_phase_e;

  // Left-justify a sample in the transmitter's 32-bit slot.
  function automatic logic [FRAME_W-1:0] slot_of(input logic [SAMPLE_W-1:0] s);
    slot_of = {s, {SAMPLE_W{1'b0}}};
  endfunction

endpackage

// File: rtl/sync_fifo_1r1w.sv
// Generic single-clock FIFO: one write port, one read port, synchronous-read RAM
// and a registered occupancy count; writes are refused only when full without a pop.
module sync_fifo_1r1w #(
  parameter int WIDTH = 32,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic [AW:0]      level_o,
  output logic             empty_o
);

  localparam logic [AW:0]   DEPTH_L = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LVL_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem_q [0:(1<<AW)-1];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic [WIDTH-1:0] rd_data_q;
  logic             do_wr_s, do_rd_s;

  // Qualify the requests and compute next pointers and level.
  always_comb begin
    do_rd_s  = rd_en_i && (level_q != '0);
    do_wr_s  = wr_en_i && ((level_q != DEPTH_L) || do_rd_s);
    wr_ptr_d = do_wr_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = do_rd_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    if (do_wr_s && !do_rd_s) begin
      level_d = level_q + LVL_ONE;
    end else if (!do_wr_s && do_rd_s) begin
      level_d = level_q - LVL_ONE;
    end else begin
      level_d = level_q;
    end
  end

  // Pointer, level and read-data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      if (do_rd_s) begin
        rd_data_q <= mem_q[rd_ptr_q];
      end
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = rd_data_q;
  assign level_o   = level_q;
  assign empty_o   = (level_q == '0);

endmodule

// File: rtl/audio_sample_feeder.sv
// Byte-stream to stereo-frame buffer feeding the I2S transmitter.
// Defining AUDIO_FEEDER_UNDERRUN_CNT_EN adds the saturating underrun_cnt output.
module audio_sample_feeder
  import audio_pkg::*;
#(
  parameter int FIFO_AW   = 9,
  parameter int REQ_LEVEL = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               byte_valid,
  input  logic [7:0]         byte_data,
  output logic               byte_ready,
  input  logic               frame_sync,
  input  logic               read_data_en,
  output logic [FRAME_W-1:0] left_data,
  output logic [FRAME_W-1:0] right_data,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               data_req,
  output logic               underrun
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]        underrun_cnt
`endif
);

  localparam logic [FIFO_AW:0] DEPTH_L = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0] REQ_L   = (FIFO_AW+1)'(REQ_LEVEL);
  localparam logic [FIFO_AW:0] ONE_L   = (FIFO_AW+1)'(1);

  byte_phase_e        phase_q, phase_d;
  logic [23:0]        partial_q, partial_d;
  logic               pend_q, pend_d;
  logic [FRAME_W-1:0] pend_frame_q, pend_frame_d;
  logic               ready_q, ready_d;
  logic               req_q, req_d;
  logic               rd_req_q;
  logic               underrun_q, underrun_d;
  logic               out_load_q, out_load_d;
  logic               out_zero_q, out_zero_d;
  logic [FRAME_W-1:0] left_q, left_d, right_q, right_d;
  logic               accept_s, pop_done_s;
  logic [FIFO_AW:0]   fifo_next_s, total_next_s;

  logic [FRAME_W-1:0] fifo_rd_data_s;
  logic [FIFO_AW:0]   fifo_level_s;
  logic               fifo_empty_s;

  sync_fifo_1r1w #(
    .WIDTH (FRAME_W),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (pend_q),
    .wr_data_i (pend_frame_q),
    .rd_en_i   (rd_req_q),
    .rd_data_o (fifo_rd_data_s),
    .level_o   (fifo_level_s),
    .empty_o   (fifo_empty_s)
  );

  assign accept_s = byte_valid && ready_q;

  // Byte assembler: a resync byte always lands in the L-lo slot.
  always_comb begin
    phase_d      = phase_q;
    partial_d    = partial_q;
    pend_d       = 1'b0;
    pend_frame_d = pend_frame_q;
    if (frame_sync) begin
      if (accept_s) begin
        phase_d   = PH_LHI;
        partial_d = {16'h0000, byte_data};
      end else begin
        phase_d   = PH_LLO;
        partial_d = 24'h000000;
      end
    end else if (accept_s) begin
      case (phase_q)
        PH_LLO: begin
          partial_d[7:0] = byte_data;
          phase_d        = PH_LHI;
        end
        PH_LHI: begin
          partial_d[15:8] = byte_data;
          phase_d         = PH_RLO;
        end
        PH_RLO: begin
          partial_d[23:16] = byte_data;
          phase_d          = PH_RHI;
        end
        PH_RHI: begin
          pend_d       = 1'b1;
          pend_frame_d = {byte_data, partial_q};
          phase_d      = PH_LLO;
        end
        default: begin
          phase_d = PH_LLO;
        end
      endcase
    end else begin
      phase_d = phase_q;
    end
  end

  // Pop pipeline, occupancy look-ahead and output stage.
  always_comb begin
    pop_done_s = rd_req_q && !fifo_empty_s;
    underrun_d = rd_req_q && fifo_empty_s;
    out_load_d = rd_req_q;
    out_zero_d = fifo_empty_s;
    if (pend_q && !pop_done_s) begin
      fifo_next_s = fifo_level_s + ONE_L;
    end else if (!pend_q && pop_done_s) begin
      fifo_next_s = fifo_level_s - ONE_L;
    end else begin
      fifo_next_s = fifo_level_s;
    end
    // The pending frame already owns a slot, so ready/req look one edge ahead.
    total_next_s = fifo_next_s + (pend_d ? ONE_L : '0);
    ready_d      = (total_next_s < DEPTH_L);
    req_d        = (total_next_s < REQ_L);
    left_d       = left_q;
    right_d      = right_q;
    if (out_load_q) begin
      if (out_zero_q) begin
        left_d  = '0;
        right_d = '0;
      end else begin
        left_d  = slot_of(fifo_rd_data_s[SAMPLE_W-1:0]);
        right_d = slot_of(fifo_rd_data_s[FRAME_W-1:SAMPLE_W]);
      end
    end else begin
      left_d  = left_q;
      right_d = right_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q      <= PH_LLO;
      partial_q    <= '0;
      pend_q       <= 1'b0;
      pend_frame_q <= '0;
      ready_q      <= 1'b0;
      req_q        <= 1'b1;
      rd_req_q     <= 1'b0;
      underrun_q   <= 1'b0;
      out_load_q   <= 1'b0;
      out_zero_q   <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
    end else begin
      phase_q      <= phase_d;
      partial_q    <= partial_d;
      pend_q       <= pend_d;
      pend_frame_q <= pend_frame_d;
      ready_q      <= ready_d;
      req_q        <= req_d;
      rd_req_q     <= read_data_en;
      underrun_q   <= underrun_d;
      out_load_q   <= out_load_d;
      out_zero_q   <= out_zero_d;
      left_q       <= left_d;
      right_q      <= right_d;
    end
  end

`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  // Saturating underrun event counter.
  always_comb begin
    if (underrun_q && (ucnt_q != 16'hFFFF)) begin
      ucnt_d = ucnt_q + 16'd1;
    end else begin
      ucnt_d = ucnt_q;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ucnt_q <= 16'h0000;
    end else begin
      ucnt_q <= ucnt_d;
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign byte_ready = ready_q;
  assign data_req   = req_q;
  assign underrun   = underrun_q;
  assign left_data  = left_q;
  assign right_data = right_q;
  assign fifo_level = fifo_level_s + (pend_q ? ONE_L : '0);

endmodule

// File: tb/tb_audio_sample_feeder.sv
// Self-checking bench for audio_sample_feeder: a byte/frame queue model predicts
// every popped frame, underrun and FIFO level.
module tb_audio_sample_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        frame_sync = 1'b0;
  logic        read_data_en = 1'b0;
  logic        byte_ready;
  logic [31:0] left_data, right_data;
  logic [9:0]  fifo_level;
  logic        data_req, underrun;
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] frames_q[$];
  logic [7:0]  part_q[$];
  logic [31:0] last_l = 32'h0;
  logic [31:0] last_r = 32'h0;
  int exp_ucnt = 0;

  audio_sample_feeder #(.FIFO_AW(9), .REQ_LEVEL(256)) dut (
    .clk          (clk),
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .rst          (rst),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .frame_sync   (frame_sync),
    .read_data_en (read_data_en),
    .left_data    (left_data),
    .right_data   (right_data),
    .fifo_level   (fifo_level),
    .data_req     (data_req),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_byte(input logic [7:0] b, input logic sync);
    if (sync) part_q.delete();
    part_q.push_back(b);
    if (part_q.size() == 4) begin
      frames_q.push_back({part_q[3], part_q[2], part_q[1], part_q[0]});
      part_q.delete();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic sync);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    byte_valid = 1'b1;
    byte_data = b;
    frame_sync = sync;
    while (!acc && n < 3000) begin
      acc = byte_ready;
      tick();
      n++;
    end
    byte_valid = 1'b0;
    frame_sync = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL send_byte: byte %h not accepted within %0d cycles", b, n);
    end else begin
      model_byte(b, sync);
    end
  endtask

  task automatic send_frames(input int nfr);
    for (int i = 0; i < 4 * nfr; i++) send_byte(8'($urandom), 1'b0);
  endtask

  task automatic sync_pulse();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
    part_q.delete();
  endtask

  task automatic read_check(input string nm, input bit chk_level);
    logic [31:0] ef, el, er;
    bit emp;
    emp = (frames_q.size() == 0);
    ef = emp ? 32'h0 : frames_q.pop_front();
    el = {ef[15:0], 16'h0000};
    er = {ef[31:16], 16'h0000};
    read_data_en = 1'b1;
    tick();
    read_data_en = 1'b0;
    tick();
    total++;
    if (underrun !== emp) begin
      bad++;
      $display("FAIL %s underrun@N+1: got %b want %b", nm, underrun, emp);
    end
    total++;
    if (left_data !== last_l || right_data !== last_r) begin
      bad++;
      $display("FAIL %s hold@N+1: got %h/%h want %h/%h", nm, left_data, right_data, last_l, last_r);
    end
    if (chk_level) begin
      total++;
      if (fifo_level !== 10'(frames_q.size())) begin
        bad++;
        $display("FAIL %s level@N+1: got %0d want %0d", nm, fifo_level, frames_q.size());
      end
    end
    tick();
    total++;
    if (underrun !== 1'b0) begin
      bad++;
      $display("FAIL %s underrun@N+2: got %b want 0", nm, underrun);
    end
    total++;
    if (left_data !== el || right_data !== er) begin
      bad++;
      $display("FAIL %s data@N+2: got %h/%h want %h/%h", nm, left_data, right_data, el, er);
    end
    if (emp && exp_ucnt < 65535) exp_ucnt++;
`ifdef AUDIO_FEEDER_UNDERRUN_CNT_EN
    total++;
    if (underrun_cnt !== 16'(exp_ucnt)) begin
      bad++;
      $display("FAIL %s underrun_cnt: got %0d want %0d", nm, underrun_cnt, exp_ucnt);
    end
`endif
    last_l = el;
    last_r = er;
  endtask

  task automatic check_level(input string nm);
    total++;
    if (fifo_level !== 10'(frames_q.size())) begin
      bad++;
      $display("FAIL %s level: got %0d want %0d", nm, fifo_level, frames_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (fifo_level !== 10'd0 || left_data !== 32'h0 || right_data !== 32'h0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: level=%0d l=%h r=%h u=%b want 0", fifo_level, left_data, right_data, underrun);
    end
    total++;
    if (byte_ready !== 1'b0 || data_req !== 1'b1) begin
      bad++;
      $display("FAIL reset_flags: ready=%b req=%b want 0/1", byte_ready, data_req);
    end
    rst = 1'b0;
    tick();
    total++;
    if (byte_ready !== 1'b1 || data_req !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_flags: ready=%b req=%b want 1/1", byte_ready, data_req);
    end
  endtask

  task automatic test_single_frame();
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    total++;
    if (fifo_level !== 10'd1) begin
      bad++;
      $display("FAIL single_level: got %0d want 1", fifo_level);
    end
    tick();
    tick();
    read_check("single", 1'b1);
    total++;
    if (left_data !== 32'h1234_0000 || right_data !== 32'h5678_0000) begin
      bad++;
      $display("FAIL single_const: got %h/%h want 12340000/56780000", left_data, right_data);
    end
  endtask

  task automatic test_underrun();
    read_check("underrun", 1'b1);
    total++;
    if (left_data !== 32'h0 || right_data !== 32'h0) begin
      bad++;
      $display("FAIL underrun_zero: got %h/%h want 0/0", left_data, right_data);
    end
  endtask

  task automatic test_resync();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    sync_pulse();
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    send_byte(8'hCC, 1'b0);
    send_byte(8'hDD, 1'b0);
    tick();
    tick();
    read_check("resync", 1'b1);
    total++;
    if (left_data !== 32'hBBAA_0000 || right_data !== 32'hDDCC_0000) begin
      bad++;
      $display("FAIL resync_const: got %h/%h want BBAA0000/DDCC0000", left_data, right_data);
    end
    send_byte(8'h77, 1'b0);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    tick();
    tick();
    read_check("resync_coincident", 1'b1);
    total++;
    if (left_data !== 32'hA55A_0000 || right_data !== 32'hC33C_0000) begin
      bad++;
      $display("FAIL resync_coincident_const: got %h/%h want A55A0000/C33C0000", left_data, right_data);
    end
  endtask

  task automatic test_push_pop_level1();
    logic [31:0] f0;
    logic [7:0] b3;
    logic acc;
    send_frames(1);
    tick();
    tick();
    check_level("pp_pre");
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    b3 = 8'($urandom);
    f0 = frames_q.pop_front();
    read_data_en = 1'b1;
    tick();
    read_data_en = 1'b0;
    byte_valid = 1'b1;
    byte_data = b3;
    acc = byte_ready;
    tick();
    byte_valid = 1'b0;
    if (acc) model_byte(b3, 1'b0);
    total++;
    if (acc !== 1'b1 || fifo_level !== 10'd1 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL pp_same_edge: acc=%b level=%0d u=%b want 1/1/0", acc, fifo_level, underrun);
    end
    tick();
    total++;
    if (fifo_level !== 10'd1 || left_data !== {f0[15:0], 16'h0} || right_data !== {f0[31:16], 16'h0}) begin
      bad++;
      $display("FAIL pp_out: level=%0d got %h/%h want 1 %h/%h", fifo_level, left_data, right_data,
               {f0[15:0], 16'h0}, {f0[31:16], 16'h0});
    end
    last_l = {f0[15:0], 16'h0};
    last_r = {f0[31:16], 16'h0};
    tick();
    read_check("pp_order", 1'b1);
  endtask

  task automatic test_data_req();
    send_frames(255);
    total++;
    if (fifo_level !== 10'd255 || data_req !== 1'b1) begin
      bad++;
      $display("FAIL req_255: level=%0d req=%b want 255/1", fifo_level, data_req);
    end
    send_frames(1);
    total++;
    if (fifo_level !== 10'd256 || data_req !== 1'b0) begin
      bad++;
      $display("FAIL req_256: level=%0d req=%b want 256/0", fifo_level, data_req);
    end
    tick();
    tick();
    read_check("req_pop", 1'b1);
    total++;
    if (data_req !== 1'b1) begin
      bad++;
      $display("FAIL req_back: got %b want 1", data_req);
    end
    while (frames_q.size() > 0) read_check("req_drain", 1'b1);
  endtask

  task automatic test_full();
    int t0;
    t0 = cyc;
    send_frames(512);
    total++;
    if (cyc - t0 != 2048) begin
      bad++;
      $display("FAIL full_throughput: got %0d cycles want 2048", cyc - t0);
    end
    total++;
    if (fifo_level !== 10'd512 || byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_state: level=%0d ready=%b want 512/0", fifo_level, byte_ready);
    end
    fork
      send_frames(1);
      begin
        tick();
        tick();
        read_check("full_pop", 1'b0);
      end
    join
    tick();
    tick();
    total++;
    if (fifo_level !== 10'd512 || byte_ready !== 1'b0 || frames_q.size() != 512) begin
      bad++;
      $display("FAIL full_refill: level=%0d ready=%b model=%0d want 512/0/512", fifo_level, byte_ready,
               frames_q.size());
    end
    while (frames_q.size() > 0) read_check("full_drain", 1'b1);
    read_check("full_empty", 1'b1);
  endtask

  task automatic test_random();
    int k;
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          k = $urandom_range(1, 10);
          for (int j = 0; j < k; j++) send_byte(8'($urandom), ($urandom_range(0, 9) == 0));
          check_level("rand_burst");
        end
        2: sync_pulse();
        default: begin
          tick();
          tick();
          read_check("rand_read", 1'b1);
        end
      endcase
    end
    sync_pulse();
    tick();
    tick();
    while (frames_q.size() > 0) read_check("rand_drain", 1'b1);
    read_check("rand_empty", 1'b1);
  endtask

  task automatic test_reset_mid();
    send_frames(101);
    tick();
    tick();
    read_check("mid_pre", 1'b1);
    send_byte(8'h9E, 1'b0);
    send_byte(8'h4F, 1'b0);
    rst = 1'b1;
    tick();
    total++;
    if (fifo_level !== 10'd0 || left_data !== 32'h0 || right_data !== 32'h0 || data_req !== 1'b1 ||
        byte_ready !== 1'b0 || underrun !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: level=%0d l=%h r=%h req=%b ready=%b u=%b", fifo_level, left_data, right_data,
               data_req, byte_ready, underrun);
    end
    rst = 1'b0;
    frames_q.delete();
    part_q.delete();
    last_l = 32'h0;
    last_r = 32'h0;
    exp_ucnt = 0;
    tick();
    send_frames(1);
    tick();
    tick();
    read_check("mid_after", 1'b1);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_underrun();
    test_resync();
    test_push_pop_level1();
    test_data_req();
    test_full();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
